par2serial_8_1: RTL
===================

PAR2SERIAL_8_1 -- requirements
Module: par2serial_8_1

Interface
REQ-001 Parameter SYNC_BYTES, default 4, number of comma bytes sent after reset before data is accepted (range 1..15).
REQ-002 Parameter COMMA, default 8'hBC, idle/alignment byte sent whenever no valid data byte is loaded.
REQ-003 clk_32f  input  1  single clock, rising-edge only; byte rate is clk_32f/8 (the clk_4f domain).
REQ-004 reset  input  1  synchronous, active-high reset sampled on rising clk_32f.
REQ-005 data_in  input  8  byte from the upstream 32-to-8 stage.
REQ-006 valid_in  input  1  data_in holds a valid byte.
REQ-007 ready_out  output  1  high during the single cycle before the edge at which data_in/valid_in are sampled.
REQ-008 data_out  output  1  serial bit stream, MSB first, registered.
REQ-009 active_out  output  1  high while in state ACTIVE.
REQ-010 tx_count  output  16  number of valid data bytes loaded since reset.

Function
REQ-011 The block SHALL keep a 3-bit bit counter bit_cnt that increments by 1 every non-reset edge and wraps 7->0.
REQ-012 A "load edge" SHALL be any non-reset edge at which bit_cnt==7; at a load edge the block selects the next byte B, drives data_out<=B[7], stores B[6:0] in a shift register.
REQ-013 At every non-load, non-reset edge, data_out SHALL take the next stored bit (B[6] down to B[0]) in order.
REQ-014 States: SYNC (reset state) and ACTIVE; no other states.
REQ-015 In SYNC, B SHALL be COMMA at every load edge regardless of valid_in; data_in is ignored; a 4-bit sync_cnt increments per load edge.
REQ-016 The load edge at which sync_cnt reaches SYNC_BYTES SHALL move state to ACTIVE; the byte loaded at that edge is still COMMA.
REQ-017 In ACTIVE, B SHALL be data_in if valid_in==1 at the load edge, else COMMA; state stays ACTIVE until reset.
REQ-018 ready_out SHALL equal (state==ACTIVE && bit_cnt==7), decoded from registers only; no combinational path from any input to any output.
REQ-019 Latency: byte sampled at load edge E appears as data_out bit 7 in the cycle after E and bit 0 in the cycle after E+7; back-to-back bytes SHALL have no gap bits.
REQ-020 tx_count SHALL increment by 1 at each ACTIVE load edge with valid_in==1; wraps 16'hFFFF->16'h0000 with no flag.
REQ-021 valid_in/data_in changes at non-load edges SHALL have no effect on data_out or tx_count.

Reset
REQ-022 At any edge with reset==1: data_out=0, ready_out=0, active_out=0, tx_count=0, sync_cnt=0, shift register=0, bit_cnt=7, state=SYNC.
REQ-023 Consequently the first edge with reset==0 SHALL be a load edge loading COMMA.
REQ-024 Reset asserted mid-byte SHALL abandon the partial byte at that edge; no remaining bits are emitted.
REQ-025 Reset held for N cycles SHALL produce identical behaviour after release for any N>=1.

Verification
REQ-026 Reset released before edge 1, valid_in=0, defaults -> data_out from edge 1 to edge 32 is 10111100 repeated 4 times; active_out rises after edge 25; ready_out high only in the cycle after edge 32.
REQ-027 After sync, valid_in=1, data_in=8'hA5 at edge 33, 8'h3C at edge 41 -> data_out bits after edges 33..48 are 10100101 00111100, no gap; tx_count=2 after edge 41.
REQ-028 valid_in=1 data_in=8'hFF throughout SYNC -> only COMMA bytes emitted, tx_count stays 0 until edge 33.
REQ-029 In ACTIVE, valid_in pulses high only at a non-load edge -> COMMA emitted, tx_count unchanged.
REQ-030 Reset asserted at edge 36 (mid-byte) for 2 cycles -> all outputs 0 after edges 36 and 37; edge 38 loads COMMA, data_out=1 after edge 38; active_out low until 24 edges later.
REQ-031 Force 65536 valid bytes in ACTIVE -> tx_count wraps to 0 and continues counting.

Source files
------------

// File: rtl/par2serial_8_1.sv
// 8:1 serializer for the clk_4f byte stream: sends COMMA alignment bytes after
// reset, then MSB-first data bytes (or COMMA when idle) at clk_32f bit rate.
module par2serial_8_1 #(
  parameter int         SYNC_BYTES = 4,
  parameter logic [7:0] COMMA      = 8'hBC
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        data_out,
  output logic        active_out,
  output logic [15:0] tx_count
);

  localparam logic STATE_SYNC   = 1'b0;
  localparam logic STATE_ACTIVE = 1'b1;

  logic        state_q,   state_d;
  logic [2:0]  bitCnt_q,  bitCnt_d;
  logic [3:0]  syncCnt_q, syncCnt_d;
  logic [6:0]  shift_q,   shift_d;
  logic        dataOut_q, dataOut_d;
  logic [15:0] txCount_q, txCount_d;
  logic [7:0]  byteSel;
  logic        loadEdge;

  assign loadEdge = (bitCnt_q == 3'd7);

  // A load edge picks the next byte; every other edge shifts out the stored bits.
  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q + 3'd1;
    syncCnt_d = syncCnt_q;
    shift_d   = {shift_q[5:0], 1'b0};
    dataOut_d = shift_q[6];
    txCount_d = txCount_q;
    byteSel   = COMMA;
    if (loadEdge) begin
      if (state_q == STATE_ACTIVE && valid_in) begin
        byteSel   = data_in;
        txCount_d = txCount_q + 16'd1;
      end
      if (state_q == STATE_SYNC) begin
        syncCnt_d = syncCnt_q + 4'd1;
        if (syncCnt_d == 4'(SYNC_BYTES)) begin
          state_d = STATE_ACTIVE;
        end
      end
      dataOut_d = byteSel[7];
      shift_d   = byteSel[6:0];
    end
  end

  // bit counter resets to 7 so the first edge after reset is a load edge
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q   <= STATE_SYNC;
      bitCnt_q  <= 3'd7;
      syncCnt_q <= 4'd0;
      shift_q   <= 7'd0;
      dataOut_q <= 1'b0;
      txCount_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      syncCnt_q <= syncCnt_d;
      shift_q   <= shift_d;
      dataOut_q <= dataOut_d;
      txCount_q <= txCount_d;
    end
  end

  assign ready_out  = (state_q == STATE_ACTIVE) && loadEdge;
  assign active_out = (state_q == STATE_ACTIVE);
  assign data_out   = dataOut_q;
  assign tx_count   = txCount_q;

endmodule
